// File: rtl/ifu_pkg.sv
// Shared IFU types and constants used by the memory arbiter and its neighbours.
package ifu_pkg;

  localparam int TAG_WIDTH = 28;
  localparam logic VALID = 1'b1;

  localparam int ARB_STARVE_LIMIT   = 4;
  localparam int ARB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } t_arb_state;

  typedef enum logic {
    OWN_CACHE,
    OWN_PREFETCH
  } t_arb_owner;

endpackage

// File: rtl/ifu_mem_arbiter_if.sv
// Request/response bundle between the cache, prefetcher, memory and the arbiter.
interface ifu_mem_arbiter_if #(
  parameter int TAG_WIDTH = ifu_pkg::TAG_WIDTH
);
  logic [TAG_WIDTH-1:0] c_reqTagIn;
  logic                 c_reqValidIn;
  logic                 c_reqReadyOut;
  logic [TAG_WIDTH-1:0] p_reqTagIn;
  logic                 p_reqValidIn;
  logic                 p_reqReadyOut;
  logic [TAG_WIDTH-1:0] mem_reqTagOut;
  logic                 mem_reqTagValidOut;
  logic                 mem_reqReadyIn;
  logic [TAG_WIDTH-1:0] mem_rspTagIn;
  logic                 mem_rspInsLineValidIn;
  logic                 c_rspValidOut;
  logic                 p_rspValidOut;
  logic                 busyOut;
  logic                 timeoutOut;

  modport slave (
    input  c_reqTagIn, c_reqValidIn, p_reqTagIn, p_reqValidIn,
           mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineValidIn,
    output c_reqReadyOut, p_reqReadyOut, mem_reqTagOut, mem_reqTagValidOut,
           c_rspValidOut, p_rspValidOut, busyOut, timeoutOut
  );

  modport master (
    output c_reqTagIn, c_reqValidIn, p_reqTagIn, p_reqValidIn,
           mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineValidIn,
    input  c_reqReadyOut, p_reqReadyOut, mem_reqTagOut, mem_reqTagValidOut,
           c_rspValidOut, p_rspValidOut, busyOut, timeoutOut
  );
endinterface

// File: rtl/ifu_mem_arbiter.sv
// Shares the single IFU memory port between cache miss fills and prefetches,
// tracking one outstanding request and routing its response to the owner.
module ifu_mem_arbiter
  import ifu_pkg::*;
#(
  parameter int TAG_WIDTH      = ifu_pkg::TAG_WIDTH,
  parameter int STARVE_LIMIT   = ARB_STARVE_LIMIT,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  ifu_mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  t_arb_state           state;
  t_arb_owner           owner_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [SW-1:0]        starve_cnt;
  logic [7:0]           to_cnt;
  logic                 timeout_q;

  logic grantC, grantP, promote, rspMatch;

  always_comb begin
    grantC   = 1'b0;
    grantP   = 1'b0;
    promote  = 1'b0;
    rspMatch = 1'b0;
    // Equal tags are served by one fill, so the prefetch rides along with the cache grant.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.c_reqValidIn && bus.p_reqValidIn && bus.c_reqTagIn == bus.p_reqTagIn) begin
            grantC = 1'b1;
            grantP = 1'b1;
          end else if (bus.c_reqValidIn && bus.p_reqValidIn && starve_cnt == STARVE_MAX) begin
            grantP = 1'b1;
          end else if (bus.c_reqValidIn) begin
            grantC = 1'b1;
          end else if (bus.p_reqValidIn) begin
            grantP = 1'b1;
          end
        end
        ISSUE, WAIT: begin
          promote = owner_q == OWN_PREFETCH && bus.c_reqValidIn && bus.c_reqTagIn == tag_q;
        end
        default: ;
      endcase
    end
    rspMatch = state == WAIT && bus.mem_rspInsLineValidIn && bus.mem_rspTagIn == tag_q;
  end

  assign bus.c_reqReadyOut      = grantC | promote;
  assign bus.p_reqReadyOut      = grantP;
  assign bus.mem_reqTagValidOut = state == ISSUE;
  assign bus.mem_reqTagOut      = (state == ISSUE) ? tag_q : '0;
  assign bus.c_rspValidOut      = rspMatch && (owner_q == OWN_CACHE || promote);
  assign bus.p_rspValidOut      = rspMatch && owner_q == OWN_PREFETCH && !promote;
  assign bus.busyOut            = state != IDLE;
  assign bus.timeoutOut         = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= OWN_CACHE;
      tag_q      <= '0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantC || grantP) begin
            tag_q   <= grantC ? bus.c_reqTagIn : bus.p_reqTagIn;
            owner_q <= grantC ? OWN_CACHE : OWN_PREFETCH;
            state   <= ISSUE;
            if (grantP)
              starve_cnt <= '0;
            else if (bus.p_reqValidIn && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ISSUE: begin
          if (promote) owner_q <= OWN_CACHE;
          if (bus.mem_reqReadyIn) begin
            state  <= WAIT;
            to_cnt <= '0;
          end
        end
        WAIT: begin
          if (promote) owner_q <= OWN_CACHE;
          if (rspMatch) begin
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
